// File: rtl/pipeline_hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard: shadow slot record and redirect FSM states.
package pipeline_hazard_scoreboard_pkg;

  // Destination field is sized for the widest register file the scoreboard accepts.
  localparam int HZ_DEST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [HZ_DEST_W-1:0] dest;
    logic                 is_load;
  } hz_slot_t;

  typedef enum logic {
    HZ_IDLE = 1'b0,
    HZ_PEND = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_scoreboard.sv
// Shadow pipeline of in-flight register writers; produces RAW stalls, redirect flushes,
// latch enables and stall/flush performance counters for the datapath.
module pipeline_hazard_scoreboard
  import pipeline_hazard_scoreboard_pkg::*;
#(
  parameter int NREG_W     = 5,
  parameter int STAGES     = 3,
  parameter int RESOLVE    = 1,
  parameter int ALU_READY  = 2,
  parameter int LOAD_READY = 2,
  parameter int CNT_W      = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dmem_wait,
  input  logic              dec_valid,
  input  logic [NREG_W-1:0] dec_rs,
  input  logic [NREG_W-1:0] dec_rt,
  input  logic              dec_uses_rs,
  input  logic              dec_uses_rt,
  input  logic              dec_wr_en,
  input  logic [NREG_W-1:0] dec_wr_addr,
  input  logic              dec_is_load,
  input  logic              redirect,
  output logic [STAGES:0]   stage_en,
  output logic [STAGES:0]   stage_flush,
  output logic              hazard,
  output logic              raw_stall,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  if (RESOLVE > STAGES - 2) begin : g_bad_resolve
    $error("RESOLVE must lie in 0..STAGES-2");
  end
  if ((ALU_READY > STAGES) || (LOAD_READY > STAGES)) begin : g_bad_ready
    $error("ALU_READY and LOAD_READY must not exceed STAGES");
  end
  if (NREG_W > HZ_DEST_W) begin : g_bad_nreg
    $error("NREG_W exceeds the slot destination field");
  end

  hz_slot_t  slot [STAGES];
  hz_state_t state, state_next;
  logic      adv;
  logic      redir_now;
  logic      any_block;

  logic [HZ_DEST_W-1:0] rs_ext, rt_ext, wr_ext;
  assign rs_ext = HZ_DEST_W'(dec_rs);
  assign rt_ext = HZ_DEST_W'(dec_rt);
  assign wr_ext = HZ_DEST_W'(dec_wr_addr);

  assign adv = ihit & ~dmem_wait;

  // A producer blocks until it reaches its readiness slot (loads may be later than ALU ops).
  always_comb begin
    any_block = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (slot[k].valid && (slot[k].dest != '0) &&
          ((dec_uses_rs && (slot[k].dest == rs_ext)) ||
           (dec_uses_rt && (slot[k].dest == rt_ext))) &&
          (k < (slot[k].is_load ? LOAD_READY : ALU_READY))) begin
        any_block = 1'b1;
      end
    end
  end

  // A redirect held while frozen is remembered in PEND and applied on the first advancing cycle.
  always_comb begin
    state_next = state;
    redir_now  = 1'b0;
    case (state)
      HZ_IDLE: begin
        if (redirect) begin
          if (adv) redir_now  = 1'b1;
          else     state_next = HZ_PEND;
        end
      end
      HZ_PEND: begin
        if (adv) begin
          redir_now  = 1'b1;
          state_next = HZ_IDLE;
        end
      end
      default: state_next = HZ_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= HZ_IDLE;
    else       state <= state_next;
  end

  // Decode is wrong-path under a redirect, so its RAW stall is dropped.
  assign raw_stall = adv & dec_valid & any_block & ~redir_now;
  assign hazard    = raw_stall | redir_now;
  assign stage_en  = {{STAGES{adv}}, adv & ~raw_stall};

  always_comb begin
    stage_flush = '0;
    if (redir_now) begin
      for (int j = 0; j <= RESOLVE + 1; j++) stage_flush[j] = 1'b1;
    end
    if (raw_stall) stage_flush[1] = 1'b1;
  end

  // Shadow pipeline advances with the datapath latches; flushed latches load an empty slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < STAGES; k++) slot[k] <= hz_slot_t'('0);
    end else if (adv) begin
      slot[0].valid   <= dec_valid & dec_wr_en & (dec_wr_addr != '0) & ~raw_stall & ~stage_flush[1];
      slot[0].dest    <= wr_ext;
      slot[0].is_load <= dec_is_load;
      for (int k = 1; k < STAGES; k++) begin
        slot[k] <= stage_flush[k+1] ? hz_slot_t'('0) : slot[k-1];
      end
    end
  end

  hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (raw_stall),
    .count (stall_cycles)
  );

  hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (redir_now),
    .count (flush_events)
  );

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed bench: default-configured scoreboard plus a full-forwarding variant with 2-bit counters.
module tb_pipeline_hazard_scoreboard;

  logic       CLK;
  logic       nRST;
  logic       ihit, dmem_wait, dec_valid;
  logic [4:0] dec_rs, dec_rt, dec_wr_addr;
  logic       dec_uses_rs, dec_uses_rt, dec_wr_en, dec_is_load, redirect;

  logic [3:0]  stage_en, stage_flush;
  logic        hazard, raw_stall;
  logic [31:0] stall_cycles, flush_events;

  logic [3:0]  f_stage_en, f_stage_flush;
  logic        f_hazard, f_raw_stall;
  logic [1:0]  f_stall_cycles, f_flush_events;

  int checks;
  int failures;

  pipeline_hazard_scoreboard dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_wait(dmem_wait), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr), .dec_is_load(dec_is_load),
    .redirect(redirect), .stage_en(stage_en), .stage_flush(stage_flush), .hazard(hazard),
    .raw_stall(raw_stall), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  pipeline_hazard_scoreboard #(.ALU_READY(0), .LOAD_READY(1), .CNT_W(2)) dut_fwd (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_wait(dmem_wait), .dec_valid(dec_valid),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
    .dec_wr_en(dec_wr_en), .dec_wr_addr(dec_wr_addr), .dec_is_load(dec_is_load),
    .redirect(redirect), .stage_en(f_stage_en), .stage_flush(f_stage_flush), .hazard(f_hazard),
    .raw_stall(f_raw_stall), .stall_cycles(f_stall_cycles), .flush_events(f_flush_events)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt,
                     input logic we, input logic [4:0] wa, input logic ld);
    dec_valid = v; dec_rs = rs; dec_uses_rs = urs; dec_rt = rt; dec_uses_rt = urt;
    dec_wr_en = we; dec_wr_addr = wa; dec_is_load = ld;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; ihit = 1'b0; dmem_wait = 1'b0; redirect = 1'b0;
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stage_en, stage_flush, hazard, raw_stall} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs en=%b flush=%b hz=%b raw=%b expected all 0",
               stage_en, stage_flush, hazard, raw_stall);
    end
    checks++;
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters stall=%0d flush=%0d expected 0 0", stall_cycles, flush_events);
    end
    ihit = 1'b1; #1;
    checks++;
    if (stage_en !== 4'b1111 || stage_flush !== 4'b0000 || hazard !== 1'b0) begin
      failures++;
      $display("FAIL reset_ihit en=%b flush=%b hz=%b expected 1111 0000 0", stage_en, stage_flush, hazard);
    end
  endtask

  task automatic test_raw_alu();
    do_reset();
    ihit = 1'b1;
    dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);   // ADD $3,$1,$2
    checks++;
    if (raw_stall !== 1'b0 || stage_en !== 4'b1111) begin
      failures++;
      $display("FAIL raw_first raw=%b en=%b expected 0 1111", raw_stall, stage_en);
    end
    step();
    dec(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0);   // SUB $6,$3,$1
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (raw_stall !== 1'b1 || stage_flush !== 4'b0010 || stage_en !== 4'b1110 || hazard !== 1'b1) begin
        failures++;
        $display("FAIL raw_stall_c%0d raw=%b flush=%b en=%b hz=%b expected 1 0010 1110 1",
                 c, raw_stall, stage_flush, stage_en, hazard);
      end
      step();
    end
    checks++;
    if (raw_stall !== 1'b0 || stage_en !== 4'b1111) begin
      failures++;
      $display("FAIL raw_release raw=%b en=%b expected 0 1111", raw_stall, stage_en);
    end
    checks++;
    if (stall_cycles !== 32'd2) begin
      failures++;
      $display("FAIL raw_count stall_cycles=%0d expected 2", stall_cycles);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    ihit = 1'b1;
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);   // LW $4
    step();
    dec(1'b1, 5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);   // ADD $5,$4,$2
    checks++;
    if (f_raw_stall !== 1'b1 || f_stage_flush !== 4'b0010) begin
      failures++;
      $display("FAIL fwd_load_use raw=%b flush=%b expected 1 0010", f_raw_stall, f_stage_flush);
    end
    step();
    checks++;
    if (f_raw_stall !== 1'b0) begin
      failures++;
      $display("FAIL fwd_load_release raw=%b expected 0", f_raw_stall);
    end
    dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0);   // ADD $7
    step();
    dec(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0);   // reads $7 twice
    checks++;
    if (f_raw_stall !== 1'b0 || f_stall_cycles !== 2'd1) begin
      failures++;
      $display("FAIL fwd_alu raw=%b stalls=%0d expected 0 1", f_raw_stall, f_stall_cycles);
    end
    for (int r = 0; r < 3; r++) begin
      step();
      dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);  // LW $9
      step();
      dec(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0);  // SW reading $9 via rt
    end
    step();
    checks++;
    if (f_stall_cycles !== 2'd3) begin
      failures++;
      $display("FAIL fwd_saturate stalls=%0d expected 3", f_stall_cycles);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    ihit = 1'b1;
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0);   // ADDI $5
    step();
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    redirect = 1'b1; #1;
    checks++;
    if (stage_flush !== 4'b0111 || stage_en !== 4'b1111 || hazard !== 1'b1 || raw_stall !== 1'b0) begin
      failures++;
      $display("FAIL redir_flush flush=%b en=%b hz=%b raw=%b expected 0111 1111 1 0",
               stage_flush, stage_en, hazard, raw_stall);
    end
    step();
    redirect = 1'b0;
    dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);   // reader of killed $5
    checks++;
    if (raw_stall !== 1'b0 || hazard !== 1'b0) begin
      failures++;
      $display("FAIL redir_killed_writer raw=%b hz=%b expected 0 0", raw_stall, hazard);
    end
    checks++;
    if (flush_events !== 32'd1) begin
      failures++;
      $display("FAIL redir_count flush_events=%0d expected 1", flush_events);
    end
  endtask

  task automatic test_pend();
    do_reset();
    redirect = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (stage_flush !== 4'b0000 || stage_en !== 4'b0000 || hazard !== 1'b0) begin
        failures++;
        $display("FAIL pend_frozen_c%0d flush=%b en=%b hz=%b expected 0000 0000 0",
                 c, stage_flush, stage_en, hazard);
      end
      step();
    end
    ihit = 1'b1; #1;
    checks++;
    if (stage_flush !== 4'b0111 || hazard !== 1'b1) begin
      failures++;
      $display("FAIL pend_apply flush=%b hz=%b expected 0111 1", stage_flush, hazard);
    end
    step();
    redirect = 1'b0; #1;
    checks++;
    if (stage_flush !== 4'b0000 || flush_events !== 32'd1) begin
      failures++;
      $display("FAIL pend_once flush=%b events=%0d expected 0000 1", stage_flush, flush_events);
    end
    redirect = 1'b1; #1;
    checks++;
    if (stage_flush !== 4'b0111) begin
      failures++;
      $display("FAIL pend_back_idle flush=%b expected 0111", stage_flush);
    end
    step();
    redirect = 1'b0; ihit = 1'b0; #1;
    checks++;
    if (flush_events !== 32'd2) begin
      failures++;
      $display("FAIL pend_count2 events=%0d expected 2", flush_events);
    end
    redirect = 1'b1;
    step();
    redirect = 1'b0;
    @(negedge CLK);
    nRST = 1'b0; #1;
    nRST = 1'b1;
    ihit = 1'b1; #1;
    checks++;
    if (stage_flush !== 4'b0000 || hazard !== 1'b0 || flush_events !== 32'd0) begin
      failures++;
      $display("FAIL pend_reset_drop flush=%b hz=%b events=%0d expected 0000 0 0",
               stage_flush, hazard, flush_events);
    end
  endtask

  task automatic test_redirect_vs_raw();
    do_reset();
    ihit = 1'b1;
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    step();
    dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0);
    redirect = 1'b1; #1;
    checks++;
    if (raw_stall !== 1'b0 || hazard !== 1'b1 || stage_en !== 4'b1111 || stage_flush !== 4'b0111) begin
      failures++;
      $display("FAIL redir_priority raw=%b hz=%b en=%b flush=%b expected 0 1 1111 0111",
               raw_stall, hazard, stage_en, stage_flush);
    end
    step();
    redirect = 1'b0;
    dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL redir_priority_count stall_cycles=%0d expected 0", stall_cycles);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    ihit = 1'b1;
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    step();
    dmem_wait = 1'b1;
    dec(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd4, 1'b0);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (stage_en !== 4'b0000 || stage_flush !== 4'b0000 || raw_stall !== 1'b0 || hazard !== 1'b0) begin
        failures++;
        $display("FAIL freeze_c%0d en=%b flush=%b raw=%b hz=%b expected 0000 0000 0 0",
                 c, stage_en, stage_flush, raw_stall, hazard);
      end
      step();
    end
    checks++;
    if (stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL freeze_count stall_cycles=%0d expected 0", stall_cycles);
    end
    dmem_wait = 1'b0; #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (raw_stall !== 1'b1) begin
        failures++;
        $display("FAIL freeze_slots_held_c%0d raw=%b expected 1", c, raw_stall);
      end
      step();
    end
    checks++;
    if (raw_stall !== 1'b0 || stall_cycles !== 32'd2) begin
      failures++;
      $display("FAIL freeze_release raw=%b stalls=%0d expected 0 2", raw_stall, stall_cycles);
    end
    dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);   // writer to $0
    step();
    dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd2, 1'b0);   // reads $0
    checks++;
    if (raw_stall !== 1'b0) begin
      failures++;
      $display("FAIL zero_reg raw=%b expected 0", raw_stall);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nRST = 1'b0; ihit = 1'b0; dmem_wait = 1'b0; redirect = 1'b0;
    dec_valid = 1'b0; dec_rs = '0; dec_rt = '0; dec_uses_rs = 1'b0; dec_uses_rt = 1'b0;
    dec_wr_en = 1'b0; dec_wr_addr = '0; dec_is_load = 1'b0;
    test_reset();
    test_raw_alu();
    test_forwarding();
    test_redirect();
    test_pend();
    test_redirect_vs_raw();
    test_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
